// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-controller FSM state encoding.
package uart_pkg;

    localparam int CLK_HZ       = 100_000_000;
    localparam int BIT_RATE     = 9600;
    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_BUSY     = 2'd2;
    localparam logic [1:0] ST_CAPTURE  = 2'd3;

    typedef enum logic [1:0] {
        DISARMED = ST_DISARMED,
        ARM      = ST_ARM,
        BUSY     = ST_BUSY,
        CAPTURE  = ST_CAPTURE
    } rx_ctrl_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with a registered head word, so the output data is stable
// while the consumer stalls and the next head appears the cycle after a pop.
module uart_rx_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == LW'(DEPTH));
    assign empty_o = (count == '0);
    assign level_o = count;
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
        head_next = data_o;
        if (do_push && (wr_ptr == rd_ptr_next)) begin
            head_next = push_data_i;
        end else if (count_next != '0) begin
            head_next = mem[rd_ptr_next];
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags do, which keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            valid_o <= (count_next != '0);
            data_o  <= head_next;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: re-arms the UART receiver after each frame, buffers
// bytes in a FIFO, and reports overrun and line-idle events.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int  FIFO_DEPTH   = 4,
    parameter int  TIMEOUT_CLKS = 41664,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    input  logic [7:0]    rx_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [7:0]    m_data_o,
    output logic [LW-1:0] level_o,
    output logic          overrun_o,
    input  logic          ovr_clr_i,
    output logic          idle_o
);

    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;

    rx_ctrl_state_e state;
    logic           capture;
    logic           pop;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [TW-1:0]  idle_timer;
    logic           idle_armed;

    assign capture = (state == CAPTURE);
    assign pop     = m_ready_i && !fifo_empty;
    assign drop    = capture && fifo_full && !pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (capture),
        .push_data_i (rx_data_i),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level_o),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o)
    );

    // The receiver cannot be aborted, so a dropped enable only takes effect
    // from DISARMED or after the in-flight frame has been captured.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= DISARMED;
            rx_valid_o <= 1'b0;
        end else begin
            unique case (state)
                DISARMED: begin
                    if (enable_i && rx_ready_i) begin
                        state      <= ARM;
                        rx_valid_o <= 1'b1;
                    end
                end
                ARM: begin
                    if (!rx_ready_i) begin
                        state      <= BUSY;
                        rx_valid_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (rx_ready_i) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (enable_i) begin
                        state      <= ARM;
                        rx_valid_o <= 1'b1;
                    end else begin
                        state <= DISARMED;
                    end
                end
                default: begin
                    state      <= DISARMED;
                    rx_valid_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overrun_o <= 1'b0;
        end else if (drop) begin
            overrun_o <= 1'b1;
        end else if (ovr_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    // Timer reads 0 the cycle after CAPTURE; matching TIMEOUT_CLKS-2 lands the
    // registered pulse exactly TIMEOUT_CLKS cycles after CAPTURE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idle_timer <= '0;
            idle_armed <= 1'b0;
            idle_o     <= 1'b0;
        end else begin
            idle_o <= 1'b0;
            if (capture) begin
                idle_timer <= '0;
                idle_armed <= 1'b1;
            end else if (idle_armed) begin
                idle_timer <= idle_timer + 1'b1;
                if (idle_timer == TW'(TIMEOUT_CLKS - 2)) begin
                    idle_o     <= 1'b1;
                    idle_armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural receiver handshake model.
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH   = 4;
    localparam int TIMEOUT_CLKS = 40;
    localparam int FRAME_CLKS   = 12;
    localparam int LW           = $clog2(FIFO_DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic          rx_valid_o;
    logic          rx_ready_i;
    logic [7:0]    rx_data_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [7:0]    m_data_o;
    logic [LW-1:0] level_o;
    logic          overrun_o;
    logic          ovr_clr_i;
    logic          idle_o;

    logic          line_go;
    logic [7:0]    line_byte;
    logic          rx_started;
    int            rx_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    uart_rx_ctrl #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_i  (rx_data_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .level_o    (level_o),
        .overrun_o  (overrun_o),
        .ovr_clr_i  (ovr_clr_i),
        .idle_o     (idle_o)
    );

    // Receiver model: idle (ready=1) until armed, then waits for a start on the
    // line, spends FRAME_CLKS cycles on the frame, presents the byte and idles.
    always @(posedge clk_i) begin
        if (reset_i) begin
            rx_ready_i <= 1'b1;
            rx_started <= 1'b0;
            rx_cnt     <= 0;
        end else if (rx_ready_i) begin
            if (rx_valid_o) rx_ready_i <= 1'b0;
            rx_started <= 1'b0;
        end else if (!rx_started) begin
            if (line_go) begin
                rx_started <= 1'b1;
                rx_cnt     <= FRAME_CLKS;
            end
        end else if (rx_cnt > 1) begin
            rx_cnt <= rx_cnt - 1;
        end else begin
            rx_data_i  <= line_byte;
            rx_ready_i <= 1'b1;
            rx_started <= 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick();
    endtask

    task automatic start_frame(input logic [7:0] b);
        int waited = 0;
        while (!(rx_ready_i == 1'b0 && rx_started == 1'b0) && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (waited >= 50) begin
            errors++;
            $display("FAIL arm_timeout: receiver never armed for byte %h", b);
        end
        line_byte = b;
        line_go   = 1'b1;
        tick();
        line_go   = 1'b0;
    endtask

    // Returns at the negedge of the first cycle with the receiver idle again.
    task automatic wait_rx_done();
        int waited = 0;
        while (rx_ready_i !== 1'b1 && waited < FRAME_CLKS + 20) begin
            tick();
            waited++;
        end
        checks++;
        if (waited >= FRAME_CLKS + 20) begin
            errors++;
            $display("FAIL frame_timeout: receiver did not finish the frame");
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        start_frame(b);
        wait_rx_done();
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== exp) begin
            errors++;
            $display("FAIL pop_data: valid=%b data=%h, expected valid=1 data=%h", m_valid_o, m_data_o, exp);
        end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
    endtask

    task automatic expect_reset_outputs(input string tag);
        checks++;
        if ({rx_valid_o, m_valid_o, m_data_o, level_o, overrun_o, idle_o} !== '0) begin
            errors++;
            $display("FAIL %s: rx_valid=%b m_valid=%b m_data=%h level=%0d overrun=%b idle=%b, expected all zero",
                     tag, rx_valid_o, m_valid_o, m_data_o, level_o, overrun_o, idle_o);
        end
    endtask

    task automatic test_reset();
        enable_i = 1'b0; m_ready_i = 1'b0; ovr_clr_i = 1'b0;
        line_go = 1'b0; line_byte = 8'h00;
        do_reset();
        expect_reset_outputs("reset_values");
        tick(3);
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disabled_no_arm: rx_valid=%b, expected 0", rx_valid_o);
        end
        enable_i = 1'b1;
        tick();
        checks++;
        if (rx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL arm_cycle_n: rx_valid=%b, expected 1", rx_valid_o);
        end
        tick();
        checks++;
        if (rx_valid_o !== 1'b1 || rx_ready_i !== 1'b0) begin
            errors++;
            $display("FAIL arm_cycle_n1: rx_valid=%b rx_ready=%b, expected 1 0", rx_valid_o, rx_ready_i);
        end
        tick();
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_cycle_n2: rx_valid=%b, expected 0", rx_valid_o);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        enable_i = 1'b1; m_ready_i = 1'b1;
        send_byte(8'hA5);
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_m: m_valid=%b, expected 0", m_valid_o);
        end
        tick();
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: m_valid=%b, expected 0", m_valid_o);
        end
        tick();
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'hA5 || level_o !== LW'(1) || rx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL single_visible: valid=%b data=%h level=%0d rx_valid=%b, expected 1 a5 1 1",
                     m_valid_o, m_data_o, level_o, rx_valid_o);
        end
        tick();
        checks++;
        if (m_valid_o !== 1'b0 || level_o !== '0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL single_popped: valid=%b level=%0d overrun=%b, expected 0 0 0",
                     m_valid_o, level_o, overrun_o);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        enable_i = 1'b1; m_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        tick(2);
        checks++;
        if (level_o !== LW'(4) || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL full_no_ovr: level=%0d overrun=%b, expected 4 0", level_o, overrun_o);
        end
        send_byte(8'h05);
        tick(2);
        checks++;
        if (level_o !== LW'(4) || overrun_o !== 1'b1 || m_data_o !== 8'h01) begin
            errors++;
            $display("FAIL overrun_set: level=%0d overrun=%b head=%h, expected 4 1 01",
                     level_o, overrun_o, m_data_o);
        end
        // Clear coincident with another drop: set wins.
        send_byte(8'h06);
        tick();
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b1 || level_o !== LW'(4)) begin
            errors++;
            $display("FAIL ovr_set_priority: overrun=%b level=%0d, expected 1 4", overrun_o, level_o);
        end
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b, expected 0", overrun_o);
        end
        // Push and pop together while full: both happen, no overrun.
        send_byte(8'h07);
        tick();
        checks++;
        if (m_data_o !== 8'h01) begin
            errors++;
            $display("FAIL full_pushpop_head: head=%h, expected 01", m_data_o);
        end
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        checks++;
        if (level_o !== LW'(4) || overrun_o !== 1'b0 || m_data_o !== 8'h02) begin
            errors++;
            $display("FAIL full_pushpop: level=%0d overrun=%b head=%h, expected 4 0 02",
                     level_o, overrun_o, m_data_o);
        end
        pop_expect(8'h02);
        pop_expect(8'h03);
        pop_expect(8'h04);
        pop_expect(8'h07);
        checks++;
        if (m_valid_o !== 1'b0 || level_o !== '0) begin
            errors++;
            $display("FAIL drained: valid=%b level=%0d, expected 0 0", m_valid_o, level_o);
        end
    endtask

    task automatic test_idle();
        int pulses = 0;
        int first  = -1;
        do_reset();
        enable_i = 1'b1; m_ready_i = 1'b1;
        for (int k = 0; k < 3 * TIMEOUT_CLKS; k++) begin
            tick();
            if (idle_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_no_traffic: pulses=%0d, expected 0", pulses);
        end
        send_byte(8'h3C);
        tick();
        for (int k = 1; k <= 3 * TIMEOUT_CLKS; k++) begin
            tick();
            if (idle_o === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (pulses != 1 || first != TIMEOUT_CLKS) begin
            errors++;
            $display("FAIL idle_pulse: pulses=%0d first_at=%0d, expected 1 at %0d", pulses, first, TIMEOUT_CLKS);
        end
    endtask

    task automatic test_disable_mid_frame();
        int armed_seen = 0;
        do_reset();
        enable_i = 1'b1; m_ready_i = 1'b1;
        start_frame(8'h5A);
        tick(3);
        enable_i = 1'b0;
        wait_rx_done();
        tick(2);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'h5A || rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_capture: valid=%b data=%h rx_valid=%b, expected 1 5a 0",
                     m_valid_o, m_data_o, rx_valid_o);
        end
        for (int k = 0; k < 60; k++) begin
            line_byte = 8'hEE;
            line_go   = (k % 15 == 0);
            tick();
            if (rx_valid_o !== 1'b0) armed_seen++;
        end
        line_go = 1'b0;
        checks++;
        if (armed_seen != 0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disabled_stays: rx_valid_high_cycles=%0d m_valid=%b, expected 0 0", armed_seen, m_valid_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        enable_i = 1'b1; m_ready_i = 1'b0;
        send_byte(8'h11);
        tick(2);
        start_frame(8'h77);
        tick(4);
        reset_i = 1'b1;
        tick();
        expect_reset_outputs("reset_mid_frame");
        reset_i = 1'b0;
        send_byte(8'hC3);
        tick(2);
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'hC3 || level_o !== LW'(1)) begin
            errors++;
            $display("FAIL first_after_reset: valid=%b data=%h level=%0d, expected 1 c3 1",
                     m_valid_o, m_data_o, level_o);
        end
        pop_expect(8'hC3);
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_drain: valid=%b, expected 0", m_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overrun();
        test_idle();
        test_disable_mid_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the byte-serial UART receiver. Re-arms the receiver after every frame through its valid/ready handshake and captures each completed byte into a small FIFO. Presents the bytes to the system on a valid/ready stream and reports overrun and line-idle events. Sits between the receiver instance and the register/DMA side of the UART controller.

## Interface
Parameters:
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- TIMEOUT_CLKS, 41664: idle gap (clk cycles, 4 bit times at 9600 baud/100 MHz) after last byte before idle_o pulses.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  keep receiver armed while high.
- rx_valid_o  out  1  to receiver valid_i; arm request.
- rx_ready_i  in  1  from receiver ready_o; high = receiver idle.
- rx_data_i  in  8  from receiver data_o; stable while rx_ready_i high.
- m_valid_o  out  1  FIFO non-empty.
- m_ready_i  in  1  consumer accepts m_data_o.
- m_data_o  out  8  FIFO head byte.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overrun_o  out  1  sticky: a byte was dropped.
- ovr_clr_i  in  1  clears overrun_o.
- idle_o  out  1  one-cycle pulse: line idle after traffic.

## Operation
- Reset values: rx_valid_o=0, m_valid_o=0, m_data_o=0, level_o=0, overrun_o=0, idle_o=0, FSM=DISARMED, FIFO empty, timer=0. The receiver is reset by the same system reset; reset mid-frame discards the partial byte.
- FSM states: DISARMED, ARM, BUSY, CAPTURE.
  - DISARMED: enable_i=1 and rx_ready_i=1 → ARM.
  - ARM: rx_valid_o=1. rx_ready_i=0 → BUSY.
  - BUSY: rx_valid_o=0. rx_ready_i=1 → CAPTURE.
  - CAPTURE: push rx_data_i into the FIFO. Then → ARM if enable_i=1, else → DISARMED.
- enable_i falling in ARM: stay in ARM until the receiver accepts, because the receiver cannot be aborted.
- enable_i falling in BUSY: the current frame completes and is captured, then → DISARMED.
- FIFO push with FIFO full and no pop in the same cycle: the byte is dropped, FIFO unchanged, overrun_o=1.
- Push and pop in the same cycle with FIFO full: both are performed, level unchanged, no overrun.
- overrun_o: set has priority over ovr_clr_i in the same cycle.
- Pop occurs when m_valid_o & m_ready_i. m_data_o must be held stable while m_valid_o=1 and m_ready_i=0.
- Idle timer: cleared on CAPTURE and armed after it; counts each cycle while armed and not in CAPTURE.
  - At TIMEOUT_CLKS-1: pulse idle_o and disarm.
  - Never pulses before the first byte after reset, and never pulses twice without an intervening byte.
- Pointers wrap modulo FIFO_DEPTH; level_o reaches FIFO_DEPTH when full.

## Timing
- rx_valid_o, m_valid_o, m_data_o, level_o, overrun_o and idle_o are all registered.
- ARM entered at cycle N: rx_valid_o=1 at N, receiver leaves idle at N+1, FSM in BUSY at N+2, rx_valid_o=0 at N+2.
- Receiver returns to idle at cycle M: CAPTURE at M+1. Byte visible on m_valid_o/m_data_o at M+2 when the FIFO was empty. Re-armed (ARM) at M+2.
- Capture-to-rearm gap is 2 cycles, far below one bit time, so no start bit is missed.
- Pop at cycle P: the next head appears at P+1. level_o updates the cycle after push/pop.
- idle_o is high for exactly one cycle, TIMEOUT_CLKS cycles after the CAPTURE cycle.

## Structure
- Shared package uart_pkg holds CLK_HZ, BIT_RATE, CLKS_PER_BIT and the ctrl FSM state encoding (2-bit localparams).
- One sub-module: uart_rx_fifo, a synchronous FIFO (push/pop/full/empty/level) parameterised by depth and width.
- uart_rx_ctrl instantiates uart_rx_fifo; the receiver is instantiated alongside it at the top level, not inside.

## Test plan
- Enable=1, send 0xA5 at 9600 baud, m_ready_i=1 → m_data_o=0xA5 pops once, level returns to 0, overrun_o=0.
- m_ready_i=0, send 0x01..0x05 with FIFO_DEPTH=4 → level_o=4, overrun_o=1, then pops yield 0x01..0x04 in order.
- overrun_o=1, assert ovr_clr_i coincident with another drop → overrun_o stays 1; clear alone → 0 next cycle.
- Send 0x3C, then silence → idle_o pulses exactly once, TIMEOUT_CLKS cycles after capture; no pulse after reset without traffic.
- Drop enable_i mid-frame 0x5A → 0x5A captured, FSM reaches DISARMED, rx_valid_o stays 0 while a further frame is sent.
- Assert reset_i mid-frame, then send 0xC3 → all outputs at reset values the cycle after reset, first captured byte is 0xC3.
